// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the multdiv unit's multiply path.
package multdiv_pkg;

  localparam int unsigned MULT_STEPS = 8;
  localparam int unsigned OPW        = 16;
  localparam int unsigned PRODW      = 32;
  localparam int unsigned CNTW       = $clog2(MULT_STEPS);

  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(MULT_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sign-extend an operand to product width.
  function automatic logic [PRODW-1:0] sext_op(input logic [OPW-1:0] x);
    return {{(PRODW - OPW){x[OPW-1]}}, x};
  endfunction

endpackage

// File: rtl/booth_module.sv
// Radix-4 Booth partial-product generator for one multiplier digit group.
// Negative digits are emitted as one's complement plus carry_out, so the sum is the two's complement.
module booth_module
  import multdiv_pkg::*;
(
  input  logic [PRODW-1:0] multiplicand,
  input  logic [OPW-1:0]   multiplier,
  input  logic [CNTW-1:0]  counter_output,
  output logic [PRODW-1:0] booth_output,
  output logic             carry_out
);

  logic [OPW:0]       mult_ext;
  logic [2:0]         triplet;
  logic [PRODW-1:0]   mag;
  logic [PRODW-1:0]   shifted;
  logic               neg;

  // Implicit zero below bit 0 for the lowest group.
  assign mult_ext = {multiplier, 1'b0};

  always_comb begin
    triplet = 3'(mult_ext >> {counter_output, 1'b0});
    mag     = '0;
    neg     = 1'b0;
    case (triplet)
      3'b001, 3'b010: mag = multiplicand;
      3'b011:         mag = multiplicand << 1;
      3'b100: begin
        mag = multiplicand << 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = multiplicand;
        neg = 1'b1;
      end
      default: ;
    endcase
    shifted      = mag << {counter_output, 1'b0};
    booth_output = neg ? ~shifted : shifted;
    carry_out    = neg;
  end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequencing controller: accepts a 16x16 signed multiply, runs eight Booth
// accumulate steps, and holds the product on a valid/ready result port.
module booth_mult_ctrl
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OPW-1:0]   op_multiplicand,
  input  logic [OPW-1:0]   op_multiplier,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PRODW-1:0] res_product,
  output logic             busy
);

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [PRODW-1:0] acc;
  logic [PRODW-1:0] mcand;
  logic [OPW-1:0]   mplier;
  logic [PRODW-1:0] booth_pp;
  logic             booth_carry;
  logic             accept;

  booth_module u_booth (
    .multiplicand   (mcand),
    .multiplier     (mplier),
    .counter_output (cnt),
    .booth_output   (booth_pp),
    .carry_out      (booth_carry)
  );

  // Ready also in DONE when the result is being taken, enabling back-to-back issue.
  assign op_ready    = (state == ST_IDLE) | ((state == ST_DONE) & res_ready);
  assign accept      = op_valid & op_ready;
  assign res_product = acc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      state     <= ST_RUN;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= sext_op(op_multiplicand);
      mplier    <= op_multiplier;
      res_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          acc <= acc + booth_pp + PRODW'(booth_carry);
          cnt <= cnt + CNTW'(1);
          if (cnt == LAST_STEP) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed bench for booth_mult_ctrl: product table plus backpressure,
// back-to-back, operand isolation and mid-operation reset sequences.
module tb_booth_mult_ctrl;

  logic        clock;
  logic        reset_n;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_multiplicand;
  logic [15:0] op_multiplier;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_product;
  logic        busy;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t tbl [12];

  booth_mult_ctrl dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .op_multiplicand (op_multiplicand),
    .op_multiplier   (op_multiplier),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_product     (res_product),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an op and return one ns after its accept edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input string name);
    int waited;
    waited = 0;
    while (!op_ready && waited < 40) begin
      tick();
      waited++;
    end
    if (!op_ready) check(32'(op_ready), 32'd1, {name, " op_ready timeout"});
    op_multiplicand = a;
    op_multiplier   = b;
    op_valid        = 1'b1;
    tick();
    op_valid = 1'b0;
  endtask

  // Called one ns after an accept edge; checks latency, busy width and product.
  task automatic wait_result(input logic [31:0] exp, input string name);
    int cyc;
    int bcnt;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!res_valid && cyc < 30) begin
      tick();
      cyc++;
      if (busy) bcnt++;
    end
    check(32'(cyc), 32'd8, {name, " latency"});
    check(32'(bcnt), 32'd8, {name, " busy cycles"});
    check(res_product, exp, {name, " product"});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    tbl[0]  = '{16'h0003, 16'h0005, 32'h0000000F};
    tbl[1]  = '{16'hFFF9, 16'h0006, 32'hFFFFFFD6};
    tbl[2]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tbl[3]  = '{16'h8000, 16'h8000, 32'h40000000};
    tbl[4]  = '{16'h8000, 16'h7FFF, 32'hC0008000};
    tbl[5]  = '{16'h0002, 16'hFFFF, 32'hFFFFFFFE};
    tbl[6]  = '{16'h0000, 16'h1234, 32'h00000000};
    tbl[7]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    tbl[8]  = '{16'h1234, 16'h0010, 32'h00012340};
    tbl[9]  = '{16'h8000, 16'h0001, 32'hFFFF8000};
    tbl[10] = '{16'hFB2E, 16'h0064, 32'hFFFE1DF8};
    tbl[11] = '{16'h0009, 16'h0009, 32'h00000051};

    reset_n         = 1'b0;
    op_valid        = 1'b0;
    op_multiplicand = '0;
    op_multiplier   = '0;
    res_ready       = 1'b1;
    repeat (3) tick();
    check(32'(op_ready), 32'd1, "reset op_ready");
    check(32'(res_valid), 32'd0, "reset res_valid");
    check(32'(busy), 32'd0, "reset busy");
    check(res_product, 32'h0, "reset res_product");
    reset_n = 1'b1;
    tick();

    // Product table with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      start_op(tbl[i].a, tbl[i].b, $sformatf("vec%0d", i));
      wait_result(tbl[i].p, $sformatf("vec%0d", i));
      tick();
      check(32'(res_valid), 32'd0, $sformatf("vec%0d res_valid drop", i));
    end

    // Backpressure: result held, requests ignored.
    res_ready = 1'b0;
    start_op(16'h0123, 16'h0045, "bp");
    wait_result(32'h00004E6F, "bp");
    begin
      int bad_hold;
      bad_hold = 0;
      for (int i = 0; i < 20; i++) begin
        op_multiplicand = 16'h0011 + 16'(i);
        op_multiplier   = 16'h0022;
        op_valid        = i[0];
        #1;
        if (op_ready !== 1'b0 || res_valid !== 1'b1 || res_product !== 32'h00004E6F || busy !== 1'b0)
          bad_hold++;
        tick();
      end
      op_valid = 1'b0;
      check(32'(bad_hold), 32'd0, "bp hold cycles");
    end
    check(res_product, 32'h00004E6F, "bp product after hold");
    res_ready = 1'b1;
    #1;
    check(32'(op_ready), 32'd1, "bp op_ready with res_ready");
    tick();
    check(32'(res_valid), 32'd0, "bp consumed");
    tick();
    check(32'(busy), 32'd0, "bp no ghost op");

    // Back-to-back: consume and accept on the same edge.
    res_ready = 1'b0;
    start_op(16'h0003, 16'h0005, "b2b first");
    wait_result(32'h0000000F, "b2b first");
    op_multiplicand = 16'h0002;
    op_multiplier   = 16'hFFFF;
    op_valid        = 1'b1;
    res_ready       = 1'b1;
    #1;
    check(32'(op_ready), 32'd1, "b2b op_ready");
    check(res_product, 32'h0000000F, "b2b first held");
    tick();
    op_valid = 1'b0;
    check(32'(busy), 32'd1, "b2b second accepted");
    wait_result(32'hFFFFFFFE, "b2b second");
    tick();

    // Operand isolation: inputs change while running.
    start_op(16'h0100, 16'h0200, "iso");
    op_multiplicand = 16'hFFFF;
    op_multiplier   = 16'hFFFF;
    wait_result(32'h00020000, "iso");
    tick();

    // Reset at RUN step 4, then a clean op.
    start_op(16'h1111, 16'h2222, "rst");
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check(32'(op_ready), 32'd1, "midrst op_ready");
    check(32'(res_valid), 32'd0, "midrst res_valid");
    check(32'(busy), 32'd0, "midrst busy");
    check(res_product, 32'h0, "midrst res_product");
    tick();
    reset_n = 1'b1;
    start_op(16'h0009, 16'h0009, "post rst");
    wait_result(32'h00000051, "post rst");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
